// File: rtl/dcache_wbuf.sv
// Write buffer between the dCache memory port and the SRAM-like bus: queues write-backs,
// drains them in order and passes refill reads through. Define WBUF_FWD_EN for read forwarding.
module dcache_wbuf #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              c_req,
   input  logic              c_wen,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_addr_ok,
   output logic              c_data_ok,
   output logic              m_req,
   output logic              m_wen,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   output logic              wbuf_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head, tail;
   logic [PTR_W:0]    count;
   logic              full, empty;
   logic              push, pop, rd_req, rd_ok, rd_done, wr_ack_q;
   logic              fwd_hit, fwd_ack_q;
   logic [DATA_W-1:0] fwd_data_q;

   assign full   = (count == DEPTH_CNT);
   assign empty  = (count == '0);
   assign push   = c_req & c_wen & ~full;
   assign rd_req = c_req & ~c_wen;

`ifdef WBUF_FWD_EN
   logic              fwd_match;
   logic [DATA_W-1:0] fwd_data;
   logic [PTR_W-1:0]  fwd_idx;

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      fwd_match = 1'b0;
      fwd_data  = '0;
      fwd_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head + PTR_W'(k);
         if (((PTR_W+1)'(k) < count) &&
             (addr_mem[fwd_idx][ADDR_W-1:2] == c_addr[ADDR_W-1:2])) begin
            fwd_match = 1'b1;
            fwd_data  = data_mem[fwd_idx];
         end
      end
   end

   assign fwd_hit = rd_req & fwd_match & (state != R_ADDR) & (state != R_DATA);
   assign rd_ok   = rd_req & ~fwd_hit & (state == IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fwd_ack_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_ack_q <= fwd_hit;
         if (fwd_hit) fwd_data_q <= fwd_data;
      end
   end
`else
   assign fwd_hit    = 1'b0;
   assign fwd_ack_q  = 1'b0;
   assign fwd_data_q = '0;
   assign rd_ok      = rd_req & empty & (state == IDLE);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         wr_ack_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state    <= state_nxt;
         wr_ack_q <= push;
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // NOTE: the entry storage is deliberately not reset; head/tail/count decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= c_addr;
         data_mem[tail] <= c_wdata;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_nxt = state;
      m_req     = 1'b0;
      m_wen     = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      c_addr_ok = push | fwd_hit;
      pop       = 1'b0;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_ok)       state_nxt = R_ADDR;
            else if (!empty) state_nxt = W_ADDR;
         end
         W_ADDR: begin
            m_req   = 1'b1;
            m_wen   = 1'b1;
            m_addr  = addr_mem[head];
            m_wdata = data_mem[head];
            if (m_addr_ok) state_nxt = W_DATA;
         end
         W_DATA: begin
            if (m_data_ok) begin
               pop       = 1'b1;
               state_nxt = IDLE;
            end
         end
         R_ADDR: begin
            m_req     = 1'b1;
            m_addr    = c_addr;
            c_addr_ok = m_addr_ok;
            if (m_addr_ok) state_nxt = R_DATA;
         end
         R_DATA: begin
            if (m_data_ok) begin
               rd_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign c_data_ok  = wr_ack_q | fwd_ack_q | rd_done;
   assign c_rdata    = rd_done ? m_rdata : (fwd_ack_q ? fwd_data_q : '0);
   assign wbuf_empty = empty & (state != W_ADDR) & (state != W_DATA);

endmodule
